// File: rtl/ps2_keys_pkg.sv
// ps2_keys_pkg
//   Shared constants for the PS/2 set-2 key tracker: scan-code bytes,
//   game-key indices, tracker FSM state encodings, the event word layout
//   and the scan-code-to-key decoder.
package ps2_keys_pkg;

    // Scan-code bytes (PS/2 set 2)
    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_B     = 8'h32;
    localparam logic [7:0] SC_C     = 8'h21;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_LEFT  = 8'h6B;

    // Game-key indices (bit position in held / press_pulse)
    localparam logic [2:0] KEY_A     = 3'd0;
    localparam logic [2:0] KEY_B     = 3'd1;
    localparam logic [2:0] KEY_C     = 3'd2;
    localparam logic [2:0] KEY_D     = 3'd3;
    localparam logic [2:0] KEY_UP    = 3'd4;
    localparam logic [2:0] KEY_DOWN  = 3'd5;
    localparam logic [2:0] KEY_RIGHT = 3'd6;
    localparam logic [2:0] KEY_LEFT  = 3'd7;

    // Prefix-tracking FSM states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_E0   = 2'd1;
    localparam logic [1:0] S_F0   = 2'd2;
    localparam logic [1:0] S_E0F0 = 2'd3;

    // Event word: {release, key}
    localparam int unsigned EVT_W = 4;

    typedef struct packed {
        logic       rel;
        logic [2:0] key;
    } evt_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_map_t;

    // Letters only decode without E0; arrows decode with E0, or without it
    // when the numeric-keypad aliases are accepted.
    function automatic key_map_t decode_key(input logic [7:0] code,
                                            input logic       ext,
                                            input logic       keypad);
        key_map_t m;
        m.hit = 1'b0;
        m.idx = KEY_A;
        case (code)
            SC_A:     if (!ext) m = '{hit: 1'b1, idx: KEY_A};
            SC_B:     if (!ext) m = '{hit: 1'b1, idx: KEY_B};
            SC_C:     if (!ext) m = '{hit: 1'b1, idx: KEY_C};
            SC_D:     if (!ext) m = '{hit: 1'b1, idx: KEY_D};
            SC_UP:    if (ext || keypad) m = '{hit: 1'b1, idx: KEY_UP};
            SC_DOWN:  if (ext || keypad) m = '{hit: 1'b1, idx: KEY_DOWN};
            SC_RIGHT: if (ext || keypad) m = '{hit: 1'b1, idx: KEY_RIGHT};
            SC_LEFT:  if (ext || keypad) m = '{hit: 1'b1, idx: KEY_LEFT};
            default:  m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo
//   Synchronous first-word-fall-through FIFO for key events.
//   Ports:
//     clk, reset   - clock, synchronous active-high reset
//     wr_en_i      - push wr_data_i (ignored when full unless popping)
//     wr_data_i    - event word to push
//     rd_en_i      - pop the head (ignored when empty)
//     rd_data_o    - head word, zero while empty
//     full_o       - DEPTH entries stored
//     empty_o      - no entries stored
module ps2_evt_fifo
    import ps2_keys_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [EVT_W-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [EVT_W-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [EVT_W-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer MSB distinguishes full (wrapped) from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    assign do_rd = rd_en_i && !empty_o;
    // On a full FIFO the write lands in the slot the same-cycle pop frees.
    assign do_wr = wr_en_i && (!full_o || do_rd);

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[PW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Turns the PS/2 set-2 byte stream into held-key state and press/release
//   events for eight game keys, tracking E0/F0 prefixes, suppressing
//   typematic repeats and abandoning stale prefixes after a timeout.
//   Ports:
//     clk, reset    - clock, synchronous active-high reset
//     rx_done_tick  - strobe: rx_data holds a new byte
//     rx_data       - received scan-code byte
//     evt_ready     - consumer takes the head event this cycle
//     clr_ovf       - clear the overflow flag
//     evt_valid     - event FIFO non-empty
//     evt_key       - head event key index
//     evt_release   - head event type (0 press, 1 release)
//     held          - held-key bitmap
//     press_pulse   - one-cycle pulse per key on a new press
//     overflow      - sticky: an event was dropped on a full FIFO
module ps2_key_tracker
    import ps2_keys_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter bit          ACCEPT_KEYPAD  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       evt_ready,
    input  logic       clr_ovf,
    output logic       evt_valid,
    output logic [2:0] evt_key,
    output logic       evt_release,
    output logic [7:0] held,
    output logic [7:0] press_pulse,
    output logic       overflow
);

    localparam int unsigned       TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       held_q, held_d;
    logic [7:0]       pulse_q, pulse_d;
    logic             ovf_q, ovf_d;

    logic             ext_pfx;
    logic             brk_pfx;
    logic             tmo_hit;
    key_map_t         kmap;
    logic             push;
    evt_t             push_evt;
    evt_t             head_evt;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;

    assign ext_pfx = (state_q == S_E0) || (state_q == S_E0F0);
    assign brk_pfx = (state_q == S_F0) || (state_q == S_E0F0);
    assign tmo_hit = (state_q != S_IDLE) && (tmo_q == TMO_LAST);
    assign kmap    = decode_key(rx_data, ext_pfx, ACCEPT_KEYPAD);

    // Prefix FSM and held/event generation. E0 always (re)starts an
    // extended prefix; F0 adds "break" while keeping any extended prefix.
    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        pulse_d  = '0;
        push     = 1'b0;
        push_evt = '0;
        if (rx_done_tick) begin
            if (rx_data == SC_E0) begin
                state_d = S_E0;
            end else if (rx_data == SC_F0) begin
                state_d = ext_pfx ? S_E0F0 : S_F0;
            end else begin
                state_d = S_IDLE;
                if (kmap.hit) begin
                    if (!brk_pfx) begin
                        if (!held_q[kmap.idx]) begin
                            held_d[kmap.idx]  = 1'b1;
                            pulse_d[kmap.idx] = 1'b1;
                            push              = 1'b1;
                            push_evt          = '{rel: 1'b0, key: kmap.idx};
                        end
                    end else if (held_q[kmap.idx]) begin
                        held_d[kmap.idx] = 1'b0;
                        push             = 1'b1;
                        push_evt         = '{rel: 1'b1, key: kmap.idx};
                    end
                end
            end
        end else if (tmo_hit) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        if (rx_done_tick || (state_q == S_IDLE)) tmo_d = '0;
        else                                     tmo_d = tmo_q + 1'b1;
    end

    assign pop  = !fifo_empty && evt_ready;
    assign drop = push && fifo_full && !pop;

    // A new drop outranks a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            held_q  <= '0;
            pulse_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            held_q  <= held_d;
            pulse_q <= pulse_d;
            ovf_q   <= ovf_d;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (push),
        .wr_data_i (push_evt),
        .rd_en_i   (evt_ready),
        .rd_data_o (head_evt),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign evt_valid   = !fifo_empty;
    assign evt_key     = head_evt.key;
    assign evt_release = head_evt.rel;
    assign held        = held_q;
    assign press_pulse = pulse_q;
    assign overflow    = ovf_q;

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Sequences the PS/2 set-2 scan-code byte stream from the keyboard receiver into key-state and key events for eight game keys (A, B, C, D, up, down, right, left). Tracks the E0 (extended) and F0 (break) prefixes with an FSM and maintains a held-key bitmap. Suppresses typematic repeats and queues press/release events in a small FIFO with a valid/ready handshake for the game logic. Sits between the PS/2 receiver (rx_done_tick, byte) and the consumers of key state.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of 2, minimum 2
TIMEOUT_CYCLES, 2500000, idle cycles after a prefix before abandoning it (50 ms at 50 MHz)
ACCEPT_KEYPAD, 1, 1 = unprefixed 75/72/74/6B also map to up/down/right/left

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_done_tick  in  1  one-cycle strobe: rx_data holds a new byte
rx_data  in  8  received scan-code byte
evt_ready  in  1  consumer accepts head event this cycle
clr_ovf  in  1  clears overflow flag
evt_valid  out  1  FIFO non-empty; head event on evt_key/evt_release
evt_key  out  3  head event key index
evt_release  out  1  head event type: 0 = press, 1 = release
held  out  8  current held bitmap, bit = key index
press_pulse  out  8  one-cycle pulse per key on a new press
overflow  out  1  sticky: an event was dropped on a full FIFO

Behaviour:
- Reset: clk and reset are as decided (reset synchronous, active-high; clock clk). State S_IDLE, held=0, press_pulse=0, FIFO empty (evt_valid=0, evt_key=0, evt_release=0), overflow=0, timeout counter=0.
- Key index: 0 A(1C), 1 B(32), 2 C(21), 3 D(23), 4 up(E0 75), 5 down(E0 72), 6 right(E0 74), 7 left(E0 6B).
- Letters map only when unprefixed. Arrows map when E0-prefixed, and also unprefixed when ACCEPT_KEYPAD=1. Extended letter codes are unmapped. Unmapped codes are ignored silently.
- FSM acts only on cycles with rx_done_tick=1:
  - S_IDLE: E0 -> S_E0; F0 -> S_F0; other -> unprefixed make, stay.
  - S_E0: F0 -> S_E0F0; E0 -> stay; other -> extended make, -> S_IDLE.
  - S_F0: E0 -> S_E0 (prefix restart); F0 -> stay; other -> unprefixed break, -> S_IDLE.
  - S_E0F0: E0 -> S_E0; F0 -> stay; other -> extended break, -> S_IDLE.
- Make of key k:
  - held[k]=0: set held[k], press_pulse[k]=1 for exactly one cycle, push {0,k}.
  - held[k]=1 (typematic repeat): no change, no event.
- Break of key k:
  - held[k]=1: clear held[k], push {1,k}.
  - held[k]=0: ignore.
- Latency: held, press_pulse and the FIFO write are registered one cycle after the rx_done_tick cycle. evt_valid rises the cycle after a push into an empty FIFO (first-word fall-through).
- Pop occurs when evt_valid && evt_ready. Push and pop in the same cycle are both honoured, including when the FIFO is full.
- Push while full without a same-cycle pop: event dropped, overflow set. held is still updated.
- clr_ovf clears overflow. If clr_ovf coincides with a new drop, the set wins.
- Timeout: counter clears on every rx_done_tick and while in S_IDLE. In any prefix state, reaching TIMEOUT_CYCLES-1 with no tick -> S_IDLE, prefix discarded. A tick on the timeout cycle wins: it is processed in the current state.
- Counter width $clog2(TIMEOUT_CYCLES+1). FIFO pointers carry an extra wrap bit for full/empty detection.
- Reset mid-sequence discards the prefix, the held state and all queued events.

Decomposition:
- Package ps2_keys_pkg: scan-code constants (E0, F0, 1C, 32, 21, 23, 75, 72, 74, 6B), key-index constants KEY_A..KEY_LEFT, FSM state encoding, event width constant (4).
- Sub-module ps2_evt_fifo: synchronous FWFT FIFO with parameter DEPTH and 4-bit data, exposing full/empty. The tracker owns overflow detection.

Test Plan:
- Bytes 1C, then F0 1C -> press_pulse[0] one cycle, held=01 then 00; FIFO yields {0,0} then {1,0}.
- Bytes E0 75, E0 75, E0 F0 75 -> single press event {0,4}, one press_pulse[4], then {1,4}; repeat suppressed; held[4] ends 0.
- evt_ready=0; press A, B, C, D, then E0 6B -> first 4 events queued, 5th dropped, overflow=1, held=8F. Pulse clr_ovf -> overflow=0.
- Full FIFO with evt_ready=1 on the same cycle as a new push -> no drop, count stays 4, overflow stays 0.
- Byte E0, then TIMEOUT_CYCLES idle cycles (small TIMEOUT_CYCLES in bench, e.g. 16), then 75 -> no event when ACCEPT_KEYPAD=0; with ACCEPT_KEYPAD=1 -> press of key 4 (unprefixed).
- Reset asserted between F0 and 1C with held[0]=1 -> held=0, FIFO empty, next 1C produces press {0,0}.
